axi4_lite_read_master_pipe: RTL and testbench
=============================================

AXI4_LITE_READ_MASTER_PIPE -- requirements
Module: axi4_lite_read_master_pipe

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, the address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, the data width.
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 4, the in-flight read limit; it must be a power of 2 and at least 1.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 256, the R-channel stall limit; 0 disables the timeout.
REQ-005 SHALL have ports:
  clk  in  1  clock
  rst  in  1  synchronous, active-low reset; one clock; reset is synchronous and active-low
  req_valid  in  1  read request valid
  req_ready  out  1  request accepted when high with req_valid
  req_addr  in  ADDR_WIDTH  read address
  rsp_valid  out  1  response available
  rsp_ready  in  1  consumer takes response
  rsp_data  out  DATA_WIDTH  read data
  rsp_resp  out  2  RRESP of this response
  rsp_err  out  1  rsp_resp[1]
  busy  out  1  any read in flight or queued
  inflight  out  $clog2(MAX_OUTSTANDING)+1  reserved slot count
  timeout_err  out  1  sticky R-channel timeout flag
  timeout_clr  in  1  clears timeout_err
  M_AXI_ARADDR  out  ADDR_WIDTH
  M_AXI_ARPROT  out  3  constant 3'b000
  M_AXI_ARVALID  out  1
  M_AXI_ARREADY  in  1
  M_AXI_RDATA  in  DATA_WIDTH
  M_AXI_RRESP  in  2
  M_AXI_RVALID  in  1
  M_AXI_RREADY  out  1

Function
REQ-006 SHALL compute inflight as the sum of three terms: AR holding register occupied (0/1), AR-accepted-not-yet-R count, and the response FIFO count.
REQ-007 SHALL drive req_ready = (inflight < MAX_OUTSTANDING) and no AR holding register pending-and-stalled.
  - i.e. req_ready is low while M_AXI_ARVALID is high and M_AXI_ARREADY is low.
REQ-008 SHALL implement the AR FSM with two states: AR_IDLE and AR_SEND.
  - AR_IDLE to AR_SEND on a request handshake; the address is latched.
  - AR_SEND to AR_IDLE on ARREADY without a new request.
  - AR_SEND stays in AR_SEND on ARREADY with a simultaneous request handshake; the new address loads.
REQ-009 SHALL assert M_AXI_ARVALID exactly in AR_SEND, starting the cycle after the request handshake.
  - ARADDR SHALL hold stable until ARREADY.
  - ARVALID SHALL never deassert before ARREADY.
REQ-010 SHALL drive M_AXI_ARADDR to 0 when ARVALID is low.
REQ-011 SHALL keep the outstanding counter as follows:
  - +1 on AR handshake; -1 on R handshake.
  - Unchanged when both occur in the same cycle.
  - It never exceeds MAX_OUTSTANDING and never underflows.
REQ-012 SHALL drive M_AXI_RREADY = (outstanding counter != 0).
  - FIFO space is guaranteed by slot reservation, so there is no FIFO-full backpressure on R.
REQ-013 SHALL push {RRESP, RDATA} into a MAX_OUTSTANDING-deep in-order FIFO on each R handshake.
  - rsp_valid rises the cycle after the R handshake; this is the fixed one-cycle latency.
REQ-014 SHALL pop the FIFO when rsp_valid and rsp_ready are both high.
  - Simultaneous push and pop keeps the count.
  - Pointers wrap modulo MAX_OUTSTANDING.
REQ-015 SHALL hold rsp_data and rsp_resp stable while rsp_valid is high and rsp_ready is low.
REQ-016 SHALL report RRESP SLVERR/DECERR through rsp_resp and rsp_err only; it does not retry or drop the response.
REQ-017 SHALL count cycles while outstanding != 0 and no R handshake occurs.
  - The counter clears on any R handshake or when outstanding == 0.
  - timeout_err is set when the count reaches TIMEOUT_CYCLES.
REQ-018 SHALL keep timeout_err set until timeout_clr.
  - Set wins over clear in the same cycle.
  - The timeout does not abort the transaction.
REQ-019 SHALL drive busy = (inflight != 0).
REQ-020 SHALL ignore an R beat that arrives while outstanding == 0; RREADY is low, so it is not accepted.

Reset
REQ-021 SHALL, while rst is low at a clk edge, force the following:
  - AR_IDLE; counters, FIFO pointers and holding register cleared.
  - Outputs: req_ready=0, ARVALID=0, ARADDR=0, RREADY=0, rsp_valid=0, rsp_data=0, rsp_resp=0, rsp_err=0, busy=0, inflight=0, timeout_err=0.
REQ-022 SHALL discard any in-flight transactions when reset is applied mid-operation; no response is produced for them after reset.
REQ-023 SHALL raise req_ready in the first cycle after rst is sampled high.

Verification
REQ-024 Single read: req 0x1000, ARREADY same cycle as ARVALID, RVALID 2 cycles later with 0xDEADBEEF/OKAY -> rsp_valid 1 cycle after R handshake, data 0xDEADBEEF, rsp_err=0, busy falls after pop.
REQ-025 Pipelining: MAX_OUTSTANDING=4, 6 back-to-back reqs, slave delays R by 10 cycles, rsp_ready=0 -> exactly 4 AR handshakes, req_ready low at inflight=4; pop resumes issue; responses return in address order.
REQ-026 Backpressure: ARREADY low 5 cycles -> ARVALID and ARADDR stable, req_ready low; then a simultaneous ARREADY and new req -> next address presented the following cycle with no bubble.
REQ-027 Error: RRESP=2'b10 with data 0x0 -> rsp_resp=2'b10, rsp_err=1; a subsequent OKAY read gives rsp_err=0.
REQ-028 Timeout: TIMEOUT_CYCLES=16, RVALID withheld -> timeout_err set on the 16th stalled cycle and remains set after RVALID.
  - timeout_clr then clears it.
  - TIMEOUT_CYCLES=0 never sets it.
REQ-029 Reset mid-flight: 3 outstanding, rst low 1 cycle -> all outputs at reset values, stray RVALID afterwards not accepted, no rsp_valid.

Source files
------------

// File: rtl/axi4_lite_read_master_pipe.sv
// AXI4-Lite read master with pipelined outstanding reads. Each accepted request
// reserves a response slot, so R never needs backpressure from the response FIFO.
module axi4_lite_read_master_pipe #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT_CYCLES  = 256
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic [ADDR_WIDTH-1:0]             req_addr,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [DATA_WIDTH-1:0]             rsp_data,
    output logic [1:0]                        rsp_resp,
    output logic                              rsp_err,
    output logic                              busy,
    output logic [$clog2(MAX_OUTSTANDING):0]  inflight,
    output logic                              timeout_err,
    input  logic                              timeout_clr,
    output logic [ADDR_WIDTH-1:0]             M_AXI_ARADDR,
    output logic [2:0]                        M_AXI_ARPROT,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0]             M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);

    localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1) + 1;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

    localparam logic AR_IDLE = 1'b0;
    localparam logic AR_SEND = 1'b1;

    logic                   ar_state;
    logic [ADDR_WIDTH-1:0]  ar_addr;
    logic                   rst_done;
    logic [CW-1:0]          out_cnt;
    logic [CW-1:0]          fifo_cnt;
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [DATA_WIDTH+1:0]  fifo_mem [MAX_OUTSTANDING];
    logic [TW-1:0]          to_cnt;

    logic req_fire, ar_fire, r_fire, pop, stall;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    assign M_AXI_ARVALID = (ar_state == AR_SEND);
    assign M_AXI_ARADDR  = M_AXI_ARVALID ? ar_addr : '0;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_RREADY  = (out_cnt != '0);

    // Every slot is counted from request acceptance until the response is popped.
    assign inflight  = CW'(ar_state) + out_cnt + fifo_cnt;
    assign busy      = (inflight != '0);
    assign req_ready = rst_done && (inflight < MAX_CNT) && !(M_AXI_ARVALID && !M_AXI_ARREADY);

    assign req_fire = req_valid && req_ready;
    assign ar_fire  = M_AXI_ARVALID && M_AXI_ARREADY;
    assign r_fire   = M_AXI_RVALID && M_AXI_RREADY;
    assign pop      = rsp_valid && rsp_ready;
    assign stall    = (out_cnt != '0) && !r_fire;

    assign rsp_valid             = (fifo_cnt != '0);
    assign {rsp_resp, rsp_data}  = rsp_valid ? fifo_mem[rd_ptr] : '0;
    assign rsp_err               = rsp_resp[1];

    always_ff @(posedge clk) begin
        if (!rst) begin
            ar_state <= AR_IDLE;
            ar_addr  <= '0;
            rst_done <= 1'b0;
        end else begin
            rst_done <= 1'b1;
            case (ar_state)
                AR_IDLE: if (req_fire) begin
                    ar_state <= AR_SEND;
                    ar_addr  <= req_addr;
                end
                default: if (M_AXI_ARREADY) begin
                    if (req_fire) begin
                        ar_addr <= req_addr;
                    end else begin
                        ar_state <= AR_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_cnt  <= '0;
            fifo_cnt <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            case ({ar_fire, r_fire})
                2'b10:   out_cnt <= out_cnt + 1'b1;
                2'b01:   out_cnt <= out_cnt - 1'b1;
                default: ;
            endcase
            case ({r_fire, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: ;
            endcase
            if (r_fire) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)    rd_ptr <= ptr_inc(rd_ptr);
        end
    end

    always_ff @(posedge clk) begin
        if (r_fire) fifo_mem[wr_ptr] <= {M_AXI_RRESP, M_AXI_RDATA};
    end

    // The flag is raised on the stalled cycle that brings the count to the limit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            to_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (!stall) begin
                to_cnt <= '0;
            end else if (to_cnt != TW'(TIMEOUT_CYCLES)) begin
                to_cnt <= to_cnt + 1'b1;
            end
            if ((TIMEOUT_CYCLES != 0) && stall && (to_cnt + 1'b1 == TW'(TIMEOUT_CYCLES))) begin
                timeout_err <= 1'b1;
            end else if (timeout_clr) begin
                timeout_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi4_lite_read_master_pipe.sv
// Directed bench for axi4_lite_read_master_pipe: a table of single reads plus
// hand-written pipelining, backpressure, timeout and mid-flight reset sequences.
module tb_axi4_lite_read_master_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_resp;
    logic        rsp_err;
    logic        busy;
    logic [2:0]  inflight;
    logic        timeout_err;
    logic        timeout_clr;
    logic [31:0] M_AXI_ARADDR;
    logic [2:0]  M_AXI_ARPROT;
    logic        M_AXI_ARVALID;
    logic        M_AXI_ARREADY;
    logic [31:0] M_AXI_RDATA;
    logic [1:0]  M_AXI_RRESP;
    logic        M_AXI_RVALID;
    logic        M_AXI_RREADY;

    logic        nt_req_ready, nt_rsp_valid, nt_rsp_err, nt_busy, nt_timeout_err;
    logic        nt_arvalid, nt_rready;
    logic [31:0] nt_rsp_data, nt_araddr;
    logic [1:0]  nt_rsp_resp;
    logic [2:0]  nt_inflight, nt_arprot;

    always #5 clk = ~clk;

    axi4_lite_read_master_pipe #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(4), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_resp(rsp_resp), .rsp_err(rsp_err), .busy(busy), .inflight(inflight),
        .timeout_err(timeout_err), .timeout_clr(timeout_clr),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
        .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
    );

    // Same stimulus, timeout disabled.
    axi4_lite_read_master_pipe #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(4), .TIMEOUT_CYCLES(0)
    ) dut_nt (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(nt_req_ready), .req_addr(req_addr),
        .rsp_valid(nt_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(nt_rsp_data),
        .rsp_resp(nt_rsp_resp), .rsp_err(nt_rsp_err), .busy(nt_busy), .inflight(nt_inflight),
        .timeout_err(nt_timeout_err), .timeout_clr(timeout_clr),
        .M_AXI_ARADDR(nt_araddr), .M_AXI_ARPROT(nt_arprot),
        .M_AXI_ARVALID(nt_arvalid), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(nt_rready)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        int          ar_delay;
        int          r_delay;
        logic [1:0]  exp_resp;
        logic        exp_err;
    } row_t;

    row_t        rows [5];
    logic [31:0] exp_q [$];
    logic [31:0] addrs [6];
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] rdata_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic run_row(input int k, input row_t r);
        int n;
        req_valid = 1'b1;
        req_addr  = r.addr;
        #1;
        n = 0;
        while (!req_ready && n < 20) begin
            step();
            #1;
            n++;
        end
        chk($sformatf("row%0d_req_ready", k), req_ready, 1);
        step();
        req_valid = 1'b0;
        for (int i = 0; i < r.ar_delay; i++) step();
        M_AXI_ARREADY = 1'b1;
        #1;
        chk($sformatf("row%0d_arvalid", k), M_AXI_ARVALID, 1);
        chk($sformatf("row%0d_araddr", k), M_AXI_ARADDR, r.addr);
        step();
        M_AXI_ARREADY = 1'b0;
        for (int i = 0; i < r.r_delay; i++) step();
        M_AXI_RVALID = 1'b1;
        M_AXI_RDATA  = r.rdata;
        M_AXI_RRESP  = r.rresp;
        #1;
        chk($sformatf("row%0d_rready", k), M_AXI_RREADY, 1);
        chk($sformatf("row%0d_no_early_rsp", k), rsp_valid, 0);
        step();
        M_AXI_RVALID = 1'b0;
        M_AXI_RDATA  = '0;
        M_AXI_RRESP  = '0;
        #1;
        chk($sformatf("row%0d_rsp_valid", k), rsp_valid, 1);
        chk($sformatf("row%0d_rsp_data", k), rsp_data, r.rdata);
        chk($sformatf("row%0d_rsp_resp", k), rsp_resp, r.exp_resp);
        chk($sformatf("row%0d_rsp_err", k), rsp_err, r.exp_err);
        chk($sformatf("row%0d_busy_before_pop", k), busy, 1);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        #1;
        chk($sformatf("row%0d_busy_after_pop", k), busy, 0);
        chk($sformatf("row%0d_rsp_valid_after_pop", k), rsp_valid, 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, req_ready, 0);
        chk({tag, "_arvalid"}, M_AXI_ARVALID, 0);
        chk({tag, "_araddr"}, M_AXI_ARADDR, 0);
        chk({tag, "_rready"}, M_AXI_RREADY, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_data"}, rsp_data, 0);
        chk({tag, "_rsp_resp"}, rsp_resp, 0);
        chk({tag, "_rsp_err"}, rsp_err, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_inflight"}, inflight, 0);
        chk({tag, "_timeout_err"}, timeout_err, 0);
    endtask

    initial begin
        int req_idx, ar_idx, r_idx, pops;
        logic [31:0] exp;

        rows[0] = '{32'h0000_1000, 32'hDEAD_BEEF, 2'b00, 0, 1, 2'b00, 1'b0};
        rows[1] = '{32'h0000_2004, 32'h0000_0000, 2'b10, 1, 0, 2'b10, 1'b1};
        rows[2] = '{32'h0000_3008, 32'h1234_5678, 2'b00, 0, 1, 2'b00, 1'b0};
        rows[3] = '{32'h0000_400C, 32'hCAFE_F00D, 2'b11, 3, 4, 2'b11, 1'b1};
        rows[4] = '{32'hFFFF_FFFC, 32'hA5A5_A5A5, 2'b01, 2, 0, 2'b01, 1'b0};
        for (int i = 0; i < 6; i++) addrs[i] = 32'h0001_0000 + 32'(i) * 32'h100;

        rst = 1'b0;
        req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0; timeout_clr = 1'b0;
        M_AXI_ARREADY = 1'b0; M_AXI_RDATA = '0; M_AXI_RRESP = '0; M_AXI_RVALID = 1'b0;

        // Reset state and release
        repeat (3) step();
        #1;
        chk_reset_outputs("reset");
        chk("reset_arprot", M_AXI_ARPROT, 0);
        rst = 1'b1;
        step();
        #1;
        chk("release_req_ready", req_ready, 1);

        // Single reads
        for (int k = 0; k < 5; k++) begin
            step();
            run_row(k, rows[k]);
        end

        // Pipelining: 6 requests, R held back, consumer stalled
        step();
        req_idx = 0; ar_idx = 0; r_idx = 0; pops = 0;
        exp_q.delete();
        for (int c = 0; c < 60; c++) begin
            req_valid     = (req_idx < 6);
            req_addr      = req_valid ? addrs[req_idx] : '0;
            M_AXI_ARREADY = 1'b1;
            M_AXI_RVALID  = (c >= 12) && (r_idx < ar_idx);
            M_AXI_RDATA   = M_AXI_RVALID ? rdata_of(addrs[r_idx]) : '0;
            M_AXI_RRESP   = 2'b00;
            rsp_ready     = (c >= 18);
            #1;
            if (c == 10) begin
                chk("pipe_ar_count", 64'(ar_idx), 4);
                chk("pipe_req_count", 64'(req_idx), 4);
                chk("pipe_req_ready_full", req_ready, 0);
                chk("pipe_inflight_full", inflight, 4);
            end
            if (c == 16) chk("pipe_inflight_fifo_full", inflight, 4);
            if (c == 17) chk("pipe_rsp_hold", rsp_data, rdata_of(addrs[0]));
            if (req_valid && req_ready) req_idx++;
            if (M_AXI_ARVALID && M_AXI_ARREADY) begin
                chk("pipe_araddr", M_AXI_ARADDR, addrs[ar_idx]);
                ar_idx++;
            end
            if (M_AXI_RVALID && M_AXI_RREADY) begin
                exp_q.push_back(rdata_of(addrs[r_idx]));
                r_idx++;
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("pipe_unexpected_rsp", rsp_valid, 0);
                end else begin
                    exp = exp_q.pop_front();
                    chk("pipe_rsp_order", rsp_data, exp);
                end
                pops++;
            end
            step();
        end
        req_valid = 1'b0; M_AXI_ARREADY = 1'b0; M_AXI_RVALID = 1'b0; rsp_ready = 1'b0;
        #1;
        chk("pipe_pops", 64'(pops), 6);
        chk("pipe_idle_inflight", inflight, 0);

        // AR backpressure, then back-to-back address with no bubble
        step();
        req_valid = 1'b1;
        req_addr  = 32'h0000_A000;
        #1;
        chk("bp_first_ready", req_ready, 1);
        step();
        req_addr = 32'h0000_B000;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_arvalid_held", M_AXI_ARVALID, 1);
            chk("bp_araddr_held", M_AXI_ARADDR, 32'h0000_A000);
            chk("bp_req_ready_low", req_ready, 0);
            step();
        end
        M_AXI_ARREADY = 1'b1;
        #1;
        chk("bp_req_ready_with_arready", req_ready, 1);
        step();
        req_valid = 1'b0;
        #1;
        chk("bp_next_arvalid", M_AXI_ARVALID, 1);
        chk("bp_next_araddr", M_AXI_ARADDR, 32'h0000_B000);
        step();
        M_AXI_ARREADY = 1'b0;
        #1;
        chk("bp_arvalid_done", M_AXI_ARVALID, 0);
        chk("bp_inflight", inflight, 2);
        M_AXI_RVALID = 1'b1;
        M_AXI_RDATA  = 32'h1111_A000;
        step();
        M_AXI_RDATA  = 32'h2222_B000;
        step();
        M_AXI_RVALID = 1'b0;
        rsp_ready    = 1'b1;
        #1;
        chk("bp_rsp0", rsp_data, 32'h1111_A000);
        step();
        #1;
        chk("bp_rsp1", rsp_data, 32'h2222_B000);
        step();
        rsp_ready = 1'b0;
        #1;
        chk("bp_busy_done", busy, 0);

        // R-channel timeout
        req_valid     = 1'b1;
        req_addr      = 32'h0000_5000;
        M_AXI_ARREADY = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        M_AXI_ARREADY = 1'b0;
        for (int i = 0; i < 15; i++) step();
        #1;
        chk("to_not_yet", timeout_err, 0);
        step();
        #1;
        chk("to_set", timeout_err, 1);
        chk("to_disabled_never_sets", nt_timeout_err, 0);
        M_AXI_RVALID = 1'b1;
        M_AXI_RDATA  = 32'h0BAD_CAFE;
        step();
        M_AXI_RVALID = 1'b0;
        #1;
        chk("to_sticky_after_r", timeout_err, 1);
        chk("to_rsp_data", rsp_data, 32'h0BAD_CAFE);
        rsp_ready = 1'b1;
        step();
        rsp_ready   = 1'b0;
        timeout_clr = 1'b1;
        #1;
        chk("to_still_set", timeout_err, 1);
        step();
        timeout_clr = 1'b0;
        #1;
        chk("to_cleared", timeout_err, 0);

        // Reset with three reads outstanding
        M_AXI_ARREADY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1;
            req_addr  = 32'h0000_C000 + 32'(i) * 4;
            step();
        end
        req_valid = 1'b0;
        step();
        M_AXI_ARREADY = 1'b0;
        #1;
        chk("rstmid_outstanding", inflight, 3);
        chk("rstmid_rready_before", M_AXI_RREADY, 1);
        step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        #1;
        chk_reset_outputs("rstmid");
        M_AXI_RVALID = 1'b1;
        M_AXI_RDATA  = 32'hFFFF_0000;
        for (int i = 0; i < 3; i++) begin
            step();
            #1;
            chk("rstmid_stray_rready", M_AXI_RREADY, 0);
            chk("rstmid_no_rsp", rsp_valid, 0);
            chk("rstmid_inflight", inflight, 0);
        end
        chk("rstmid_req_ready", req_ready, 1);
        M_AXI_RVALID = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
